// File: rtl/branch_resolver.sv
// Branch resolver: issues predictor requests for fetched branches, holds the
// predictions in program order and resolves them against execute outcomes.
module branch_resolver #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fetch_valid,
    output logic                       fetch_ready,
    output logic                       fetch_pred_valid,
    output logic                       fetch_pred,
    output logic                       request,
    input  logic                       prediction,
    input  logic                       exec_valid,
    input  logic                       exec_taken,
    output logic                       result,
    output logic                       taken,
    output logic                       mispredict,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [CNT_W-1:0]           branch_count,
    output logic [CNT_W-1:0]           miss_count,
    output logic                       err_underflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    logic             r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [OCC_W-1:0] r_count;
    logic             r_cap_pend;
    logic             r_result;
    logic             r_taken;
    logic             r_mispredict;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_miss_cnt;
    logic             r_err_uf;

    logic [OCC_W-1:0] w_occ;
    logic             w_accept;
    logic             w_pop;
    logic             w_miss;
    logic             w_push;

    // A pending capture reserves a slot but cannot be resolved yet.
    always_comb begin
        w_occ    = r_count + OCC_W'(r_cap_pend);
        w_accept = fetch_valid & (w_occ < OCC_W'(DEPTH));
        w_pop    = exec_valid & (r_count != OCC_W'(0));
        w_miss   = w_pop & (r_mem[r_head] != exec_taken);
        w_push   = r_cap_pend & ~w_miss;
    end

    assign fetch_ready      = w_occ < OCC_W'(DEPTH);
    assign request          = w_accept;
    assign fetch_pred_valid = r_cap_pend;
    assign fetch_pred       = r_cap_pend & prediction;
    assign occupancy        = w_occ;
    assign result           = r_result;
    assign taken            = r_taken;
    assign mispredict       = r_mispredict;
    assign branch_count     = r_branch_cnt;
    assign miss_count       = r_miss_cnt;
    assign err_underflow    = r_err_uf;

    // Prediction storage carries no reset; validity is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= prediction;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_cap_pend <= 1'b0;
        end else if (w_miss) begin
            // Mispredict flushes every younger branch, including a same-cycle accept.
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_cap_pend <= 1'b0;
        end else begin
            r_cap_pend <= w_accept;
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            r_count <= r_count + OCC_W'(w_push) - OCC_W'(w_pop);
        end
    end

    // Training pulse, outcome and statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result     <= 1'b0;
            r_taken      <= 1'b0;
            r_mispredict <= 1'b0;
            r_branch_cnt <= '0;
            r_miss_cnt   <= '0;
            r_err_uf     <= 1'b0;
        end else begin
            r_result     <= w_pop;
            r_mispredict <= w_miss;
            if (w_pop) begin
                r_taken <= exec_taken;
            end
            if (w_pop && !(&r_branch_cnt)) begin
                r_branch_cnt <= r_branch_cnt + CNT_W'(1);
            end
            if (w_miss && !(&r_miss_cnt)) begin
                r_miss_cnt <= r_miss_cnt + CNT_W'(1);
            end
            if (exec_valid && (r_count == OCC_W'(0))) begin
                r_err_uf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolver.sv
// Table-driven bench for branch_resolver with a result scoreboard; a second
// instance with 2-bit counters covers statistics saturation.
module tb_branch_resolver;

    localparam int unsigned OCC_W = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic fetch_valid = 1'b0;
    logic prediction  = 1'b0;
    logic exec_valid  = 1'b0;
    logic exec_taken  = 1'b0;

    logic             fetch_ready, fetch_pred_valid, fetch_pred, request;
    logic             result, taken, mispredict, err_underflow;
    logic [OCC_W-1:0] occupancy;
    logic [15:0]      branch_count, miss_count;

    logic             s_ready, s_fpv, s_fp, s_req, s_result, s_taken, s_mis, s_err;
    logic [OCC_W-1:0] s_occ;
    logic [1:0]       s_branch_count, s_miss_count;

    branch_resolver #(.DEPTH(4), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .fetch_pred_valid(fetch_pred_valid), .fetch_pred(fetch_pred),
        .request(request), .prediction(prediction),
        .exec_valid(exec_valid), .exec_taken(exec_taken),
        .result(result), .taken(taken), .mispredict(mispredict),
        .occupancy(occupancy), .branch_count(branch_count),
        .miss_count(miss_count), .err_underflow(err_underflow)
    );

    branch_resolver #(.DEPTH(4), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst),
        .fetch_valid(fetch_valid), .fetch_ready(s_ready),
        .fetch_pred_valid(s_fpv), .fetch_pred(s_fp),
        .request(s_req), .prediction(prediction),
        .exec_valid(exec_valid), .exec_taken(exec_taken),
        .result(s_result), .taken(s_taken), .mispredict(s_mis),
        .occupancy(s_occ), .branch_count(s_branch_count),
        .miss_count(s_miss_count), .err_underflow(s_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic fv, pr, ev, et;
        logic rdy, req, fpv, fp;
        logic [OCC_W-1:0] occ;
        logic res, mis;
    } vec_t;

    typedef struct {
        int   cyc;
        logic tk;
        logic mis;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    function automatic void add(input int fv, input int pr, input int ev, input int et,
                                input int rdy, input int req, input int fpv, input int fp,
                                input int occ, input int res, input int mis);
        vec_t v;
        v.fv  = 1'(fv);  v.pr  = 1'(pr);  v.ev  = 1'(ev);  v.et = 1'(et);
        v.rdy = 1'(rdy); v.req = 1'(req); v.fpv = 1'(fpv); v.fp = 1'(fp);
        v.occ = OCC_W'(occ); v.res = 1'(res); v.mis = 1'(mis);
        tbl.push_back(v);
    endfunction

    // Apply one vector per cycle; combinational outputs checked mid-cycle.
    task automatic run_tbl(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            fetch_valid = tbl[i].fv;
            prediction  = tbl[i].pr;
            exec_valid  = tbl[i].ev;
            exec_taken  = tbl[i].et;
            #1;
            chk($sformatf("%s[%0d].fetch_ready", tag, i), 32'(fetch_ready), 32'(tbl[i].rdy));
            chk($sformatf("%s[%0d].request", tag, i), 32'(request), 32'(tbl[i].req));
            chk($sformatf("%s[%0d].fetch_pred_valid", tag, i), 32'(fetch_pred_valid), 32'(tbl[i].fpv));
            if (tbl[i].fpv)
                chk($sformatf("%s[%0d].fetch_pred", tag, i), 32'(fetch_pred), 32'(tbl[i].fp));
            chk($sformatf("%s[%0d].occupancy", tag, i), 32'(occupancy), 32'(tbl[i].occ));
            if (tbl[i].res) begin
                exp_t e;
                e.cyc = cyc + 1;
                e.tk  = tbl[i].et;
                e.mis = tbl[i].mis;
                exp_q.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        fetch_valid = 1'b0;
        prediction  = 1'b0;
        exec_valid  = 1'b0;
        exec_taken  = 1'b0;
        tbl.delete();
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        fetch_valid = 1'b0;
        exec_valid  = 1'b0;
        prediction  = 1'b1;
        exp_q.delete();
        #1;
        chk("rst.fetch_pred_valid", 32'(fetch_pred_valid), 0);
        chk("rst.fetch_pred", 32'(fetch_pred), 0);
        chk("rst.result", 32'(result), 0);
        chk("rst.taken", 32'(taken), 0);
        chk("rst.mispredict", 32'(mispredict), 0);
        chk("rst.occupancy", 32'(occupancy), 0);
        chk("rst.fetch_ready", 32'(fetch_ready), 1);
        chk("rst.request", 32'(request), 0);
        chk("rst.branch_count", 32'(branch_count), 0);
        chk("rst.miss_count", 32'(miss_count), 0);
        chk("rst.err_underflow", 32'(err_underflow), 0);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        prediction = 1'b0;
    endtask

    // Scoreboard: every result pulse must match the oldest expected resolve.
    always @(negedge clk) begin
        if (!rst) begin
            if (result) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb.unexpected_result: got result=1 expected none (t=%0t)", $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb.result_cycle", 32'(cyc), 32'(e.cyc));
                    chk("sb.taken", 32'(taken), 32'(e.tk));
                    chk("sb.mispredict", 32'(mispredict), 32'(e.mis));
                end
            end else if (mispredict) begin
                chk("sb.mispredict_without_result", 32'(mispredict), 0);
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        // Basic in-order resolve, predictions 1,1,0.
        add(1,0,0,0, 1,1,0,0, 0, 0,0);
        add(1,1,0,0, 1,1,1,1, 1, 0,0);
        add(1,1,0,0, 1,1,1,1, 2, 0,0);
        add(0,0,0,0, 1,0,1,0, 3, 0,0);
        add(0,0,1,1, 1,0,0,0, 3, 1,0);
        add(0,0,1,1, 1,0,0,0, 2, 1,0);
        add(0,0,1,0, 1,0,0,0, 1, 1,0);
        add(0,0,0,0, 1,0,0,0, 0, 0,0);
        run_tbl("basic");
        chk("basic.branch_count", 32'(branch_count), 3);
        chk("basic.miss_count", 32'(miss_count), 0);

        // Mispredict flush then underflow.
        do_reset();
        add(1,0,0,0, 1,1,0,0, 0, 0,0);
        add(1,1,0,0, 1,1,1,1, 1, 0,0);
        add(1,1,0,0, 1,1,1,1, 2, 0,0);
        add(0,1,0,0, 1,0,1,1, 3, 0,0);
        add(0,0,1,0, 1,0,0,0, 3, 1,1);
        add(0,0,0,0, 1,0,0,0, 0, 0,0);
        run_tbl("flush");
        chk("flush.branch_count", 32'(branch_count), 1);
        chk("flush.miss_count", 32'(miss_count), 1);
        chk("flush.err_underflow_clear", 32'(err_underflow), 0);
        add(0,0,1,1, 1,0,0,0, 0, 0,0);
        add(0,0,0,0, 1,0,0,0, 0, 0,0);
        add(0,0,0,0, 1,0,0,0, 0, 0,0);
        run_tbl("underflow");
        chk("underflow.err_underflow", 32'(err_underflow), 1);
        chk("underflow.branch_count", 32'(branch_count), 1);
        chk("underflow.miss_count", 32'(miss_count), 1);

        // Full queue, backpressure and pointer wrap.
        do_reset();
        add(1,0,0,0, 1,1,0,0, 0, 0,0);
        add(1,1,0,0, 1,1,1,1, 1, 0,0);
        add(1,0,0,0, 1,1,1,0, 2, 0,0);
        add(1,1,0,0, 1,1,1,1, 3, 0,0);
        add(1,1,0,0, 0,0,1,1, 4, 0,0);
        add(1,0,0,0, 0,0,0,0, 4, 0,0);
        add(1,0,1,1, 0,0,0,0, 4, 1,0);
        add(1,0,0,0, 1,1,0,0, 3, 0,0);
        add(0,0,0,0, 0,0,1,0, 4, 0,0);
        add(0,0,1,0, 0,0,0,0, 4, 1,0);
        add(0,0,1,1, 1,0,0,0, 3, 1,0);
        add(0,0,1,1, 1,0,0,0, 2, 1,0);
        add(0,0,1,0, 1,0,0,0, 1, 1,0);
        add(0,0,0,0, 1,0,0,0, 0, 0,0);
        run_tbl("full");
        chk("full.branch_count", 32'(branch_count), 5);
        chk("full.miss_count", 32'(miss_count), 0);

        // Accept alongside a correct resolve, then alongside a mispredict.
        do_reset();
        add(1,0,0,0, 1,1,0,0, 0, 0,0);
        add(1,1,0,0, 1,1,1,1, 1, 0,0);
        add(0,0,0,0, 1,0,1,0, 2, 0,0);
        add(0,0,0,0, 1,0,0,0, 2, 0,0);
        add(1,0,1,1, 1,1,0,0, 2, 1,0);
        add(0,0,0,0, 1,0,1,0, 2, 0,0);
        add(0,0,0,0, 1,0,0,0, 2, 0,0);
        add(1,0,1,1, 1,1,0,0, 2, 1,1);
        add(0,1,0,0, 1,0,0,0, 0, 0,0);
        add(0,0,0,0, 1,0,0,0, 0, 0,0);
        run_tbl("simul");
        chk("simul.branch_count", 32'(branch_count), 2);
        chk("simul.miss_count", 32'(miss_count), 1);

        // Asynchronous reset with a result pulse and a capture outstanding.
        do_reset();
        add(1,0,0,0, 1,1,0,0, 0, 0,0);
        add(1,1,0,0, 1,1,1,1, 1, 0,0);
        add(1,1,0,0, 1,1,1,1, 2, 0,0);
        add(0,1,0,0, 1,0,1,1, 3, 0,0);
        run_tbl("arst_fill");
        fetch_valid = 1'b1;
        exec_valid  = 1'b1;
        exec_taken  = 1'b1;
        @(posedge clk);
        #1;
        fetch_valid = 1'b0;
        exec_valid  = 1'b0;
        prediction  = 1'b1;
        chk("arst.pre_result", 32'(result), 1);
        chk("arst.pre_fetch_pred_valid", 32'(fetch_pred_valid), 1);
        do_reset();
        add(0,0,0,0, 1,0,0,0, 0, 0,0);
        add(0,0,0,0, 1,0,0,0, 0, 0,0);
        add(0,0,0,0, 1,0,0,0, 0, 0,0);
        run_tbl("arst_after");
        chk("arst.branch_count", 32'(branch_count), 0);

        // Five mispredicting single-branch rounds.
        do_reset();
        for (int r = 0; r < 5; r++) begin
            add(1,0,0,0, 1,1,0,0, 0, 0,0);
            add(0,1,0,0, 1,0,1,1, 1, 0,0);
            add(0,0,1,0, 1,0,0,0, 1, 1,1);
            add(0,0,0,0, 1,0,0,0, 0, 0,0);
        end
        run_tbl("sat");
        chk("sat.branch_count_wide", 32'(branch_count), 5);
        chk("sat.miss_count_wide", 32'(miss_count), 5);
        chk("sat.branch_count_2b", 32'(s_branch_count), 3);
        chk("sat.miss_count_2b", 32'(s_miss_count), 3);

        repeat (2) @(posedge clk);
        #1;
        chk("sb.pending_left", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
